// File: rtl/ahb_button_pkg.sv
// Shared constants and event type for the button filter.
// Included by the channel and top-level modules.
package ahb_button_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 830;
    localparam int LONG_CYCLES_DEF     = 66400;
    localparam int N_CH_MAX            = 16;

    typedef enum logic [1:0] {
        EVT_NONE,
        EVT_PRESS,
        EVT_RELEASE,
        EVT_LONG
    } btn_evt_t;

endpackage

// File: rtl/ahb_button_chan.sv
// One button channel: synchroniser, integrator, pulses, hold counter.
// Long-press logic is present only when AHB_BUTTON_LONGPRESS_EN is defined.
module ahb_button_chan
    import ahb_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_pressed,
    output logic o_press_p,
    output logic o_release_p,
    output logic o_long_p
);

    localparam logic REL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int   CW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 1) begin : g_chk_long
        $error("LONG_CYCLES must be at least 1");
    end

    logic          r_sync1;
    logic          r_sync2;
    logic          r_s;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_pressed;
    logic          r_press_p;
    logic          r_release_p;

    logic          w_level_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_pressed_nxt;

    // Integrator: climbs on mismatch, decays on match, commits at the top
    always_comb begin
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        if (r_s != r_level) begin
            if (r_cnt == CNT_TOP) begin
                w_level_nxt = r_s;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
        w_pressed_nxt = w_level_nxt ^ REL;
    end

    // Synchroniser, sample, debounced level and edge pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= REL;
            r_sync2     <= REL;
            r_s         <= REL;
            r_level     <= REL;
            r_cnt       <= '0;
            r_pressed   <= 1'b0;
            r_press_p   <= 1'b0;
            r_release_p <= 1'b0;
        end else begin
            r_sync1     <= i_btn;
            r_sync2     <= r_sync1;
            r_s         <= r_sync2;
            r_level     <= w_level_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pressed   <= w_pressed_nxt;
            r_press_p   <= w_pressed_nxt & ~r_pressed;
            r_release_p <= ~w_pressed_nxt & r_pressed;
        end
    end

    assign o_level     = r_level;
    assign o_pressed   = r_pressed;
    assign o_press_p   = r_press_p;
    assign o_release_p = r_release_p;

`ifdef AHB_BUTTON_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_TOP = HW'(LONG_CYCLES);

    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          w_long_nxt;
    logic          r_long_p;

    // Hold counter: cleared on release, saturates at the long threshold;
    // a release on the reaching cycle wins so no long pulse is issued
    always_comb begin
        w_hold_nxt = r_hold;
        w_long_nxt = 1'b0;
        if (!w_pressed_nxt) begin
            w_hold_nxt = '0;
        end else if (r_pressed && (r_hold != HOLD_TOP)) begin
            w_hold_nxt = r_hold + 1'b1;
            w_long_nxt = (w_hold_nxt == HOLD_TOP);
        end
    end

    // Hold counter and long-press pulse registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold   <= '0;
            r_long_p <= 1'b0;
        end else begin
            r_hold   <= w_hold_nxt;
            r_long_p <= w_long_nxt;
        end
    end

    assign o_long_p = r_long_p;
`else
    assign o_long_p = 1'b0;
`endif

endmodule

// File: rtl/ahb_button_filter.sv
// Multi-channel button debouncer with press/release/long-press pulses.
// Long-press detection is built only with AHB_BUTTON_LONGPRESS_EN defined.
module ahb_button_filter
    import ahb_button_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_pressed,
    output logic [N_CH-1:0] press_p,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] long_p
);

    if ((N_CH < 1) || (N_CH > N_CH_MAX)) begin : g_chk_nch
        $error("N_CH out of range 1..16");
    end

    // Fully independent channels, no arbitration between them
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        ahb_button_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .i_clk       (HCLK),
            .i_rst_n     (HRESETn),
            .i_btn       (btn_in[gi]),
            .o_level     (btn_level[gi]),
            .o_pressed   (btn_pressed[gi]),
            .o_press_p   (press_p[gi]),
            .o_release_p (release_p[gi]),
            .o_long_p    (long_p[gi])
        );
    end

endmodule
